// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared definitions for the frame buffer write side.
//   wr_state_t          - write FSM state encoding
//   ASSERT_L/DEASSERT_L - levels for the memory's active-low strobes
package frame_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'h0,
        ST_HOLD = 2'h1,
        ST_GAP  = 2'h2
    } wr_state_t;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous FIFO, registered occupancy count, no bypass.
//   pll0_pll_clk_clk, reset - clock, synchronous active-high reset
//   push, din               - write side (ignored when full)
//   pop, dout               - read side; dout shows the head combinationally
//   full, empty             - occupancy flags
module pix_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             pll0_pll_clk_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge pll0_pll_clk_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge pll0_pll_clk_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_buf_wr_ctrl.sv
// frame_buf_wr_ctrl: buffers a pixel stream and writes it to the frame
// buffer memory at sequential, wrapping addresses, holding each write for
// WR_HOLD cycles followed by a one-cycle gap.
//   pll0_pll_clk_clk, reset     - clock, synchronous active-high reset
//   pix_data/pix_sof/pix_valid  - pixel stream in; pix_ready = FIFO not full
//   rd_en                       - memory read strobe (active-low), monitored
//   wr_addr/wr_data/wr_en       - memory write port (wr_en active-low)
//   frame_done                  - pulse in the gap after the last frame pixel
module frame_buf_wr_ctrl
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 29,
    parameter int ADDR_BASE    = 1,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 4,
    parameter int WR_HOLD      = 3
) (
    input  logic                  pll0_pll_clk_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_sof,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  frame_done
);

    localparam int FW = DATA_WIDTH + 1;
    localparam int CW = $clog2(WR_HOLD + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(64'(ADDR_BASE) + 64'(FRAME_PIXELS) - 64'd1);

    wr_state_t             state, state_next;
    logic [CW-1:0]         hold_cnt, hold_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_cnt, addr_cnt_next;
    logic                  retry_valid, retry_next;
    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_next;
    logic                  wr_en_next;
    logic                  frame_done_next;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_dout;

    assign pix_ready = !fifo_full;
    assign fifo_push = pix_valid && pix_ready;

    pix_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pll0_pll_clk_clk (pll0_pll_clk_clk),
        .reset            (reset),
        .push             (fifo_push),
        .pop              (fifo_pop),
        .din              ({pix_sof, pix_data}),
        .dout             (fifo_dout),
        .full             (fifo_full),
        .empty            (fifo_empty)
    );

    always_comb begin
        state_next      = state;
        hold_cnt_next   = hold_cnt;
        addr_cnt_next   = addr_cnt;
        retry_next      = retry_valid;
        wr_addr_next    = wr_addr;
        wr_data_next    = wr_data;
        wr_en_next      = wr_en;
        frame_done_next = 1'b0;
        fifo_pop        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rd_en == DEASSERT_L) begin
                    // An interrupted write still sits in wr_addr/wr_data,
                    // so a retry only needs to re-assert the strobe.
                    if (retry_valid) begin
                        retry_next    = 1'b0;
                        wr_en_next    = ASSERT_L;
                        hold_cnt_next = CW'(1);
                        state_next    = ST_HOLD;
                    end else if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        wr_data_next  = fifo_dout[DATA_WIDTH-1:0];
                        wr_addr_next  = fifo_dout[FW-1] ? BASE_ADDR : addr_cnt;
                        wr_en_next    = ASSERT_L;
                        hold_cnt_next = CW'(1);
                        state_next    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (rd_en == ASSERT_L) begin
                    wr_en_next = DEASSERT_L;
                    retry_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (hold_cnt == CW'(WR_HOLD)) begin
                    wr_en_next      = DEASSERT_L;
                    frame_done_next = (wr_addr == LAST_ADDR);
                    state_next      = ST_GAP;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                addr_cnt_next = (wr_addr == LAST_ADDR) ? BASE_ADDR : wr_addr + 1'b1;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pll0_pll_clk_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            addr_cnt    <= BASE_ADDR;
            retry_valid <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= DEASSERT_L;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            addr_cnt    <= addr_cnt_next;
            retry_valid <= retry_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            wr_en       <= wr_en_next;
            frame_done  <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_frame_buf_wr_ctrl.sv
// tb_frame_buf_wr_ctrl: self-checking bench for frame_buf_wr_ctrl with a
// 4-pixel frame. A reference model assigns each accepted pixel its frame
// address; a monitor matches every write strobe run against it.
module tb_frame_buf_wr_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 29;
    localparam int BASE  = 1;
    localparam int FP    = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam logic [AW-1:0] LAST = AW'(BASE + FP - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic          rd_en = 1'b1;
    logic          pix_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buf_wr_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .ADDR_BASE    (BASE),
        .FRAME_PIXELS (FP),
        .FIFO_DEPTH   (DEPTH),
        .WR_HOLD      (HOLD)
    ) dut (
        .pll0_pll_clk_clk (clk),
        .reset            (reset),
        .pix_data         (pix_data),
        .pix_sof          (pix_sof),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .rd_en            (rd_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .frame_done       (frame_done)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e_new;
    logic [AW-1:0] commits[$];
    logic [DW-1:0] sent_data[$];
    logic [AW-1:0] mcnt = AW'(BASE);
    int            acc_n = 0;
    int            pop_n = 0;
    int            done_pulses = 0;
    bit            rst_edge = 1'b0;
    logic          rd_edge = 1'b1;

    // Accepted pixels get their address from the frame rules at accept time.
    always @(posedge clk) begin
        rst_edge = reset;
        rd_edge  = rd_en;
        if (reset) begin
            exp_q.delete();
            mcnt  = AW'(BASE);
            acc_n = 0;
        end else if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            e_new.addr = pix_sof ? AW'(BASE) : mcnt;
            e_new.data = pix_data;
            e_new.done = (e_new.addr == LAST);
            mcnt       = e_new.done ? AW'(BASE) : e_new.addr + 1'b1;
            exp_q.push_back(e_new);
            acc_n++;
        end
    end

    // ---------------- write-port monitor ----------------
    int            run_len = 0;
    int            high_len = 0;
    bit            aborted = 1'b0;
    bit            last_commit = 1'b0;
    logic          exp_fd;
    logic [AW-1:0] run_addr;
    logic [DW-1:0] run_data;

    always @(negedge clk) begin
        if (rst_edge) begin
            run_len     = 0;
            high_len    = 0;
            aborted     = 1'b0;
            last_commit = 1'b0;
            pop_n       = 0;
        end else begin
            if (wr_en === 1'b0) begin
                if (run_len == 0) begin
                    if (!aborted) pop_n++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: addr=%0d data=%h with no pixel outstanding", wr_addr, wr_data);
                    end else if (wr_addr !== exp_q[0].addr || wr_data !== exp_q[0].data) begin
                        errors++;
                        $display("FAIL write_start: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 wr_addr, wr_data, exp_q[0].addr, exp_q[0].data);
                    end
                    if (last_commit) begin
                        checks++;
                        if (high_len < 2) begin
                            errors++;
                            $display("FAIL write_gap: wr_en high for %0d cycles between writes, expected >= 2", high_len);
                        end
                    end
                    run_addr = wr_addr;
                    run_data = wr_data;
                    aborted  = 1'b0;
                    high_len = 0;
                end else begin
                    checks++;
                    if (wr_addr !== run_addr || wr_data !== run_data) begin
                        errors++;
                        $display("FAIL hold_stable: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 wr_addr, wr_data, run_addr, run_data);
                    end
                end
                run_len++;
                checks++;
                if (run_len > HOLD) begin
                    errors++;
                    $display("FAIL hold_len: wr_en low for %0d cycles, expected at most %0d", run_len, HOLD);
                end
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_hold: got %b during write, expected 0", frame_done);
                end
            end else begin
                exp_fd = 1'b0;
                if (run_len > 0) begin
                    if (rd_edge === 1'b0) begin
                        aborted     = 1'b1;
                        last_commit = 1'b0;
                    end else begin
                        checks++;
                        if (run_len != HOLD) begin
                            errors++;
                            $display("FAIL hold_short: wr_en low for %0d cycles, expected %0d", run_len, HOLD);
                        end
                        if (exp_q.size() > 0) begin
                            exp_fd = exp_q[0].done;
                            exp_q.pop_front();
                        end
                        commits.push_back(run_addr);
                        last_commit = 1'b1;
                    end
                end
                checks++;
                if (frame_done !== exp_fd) begin
                    errors++;
                    $display("FAIL frame_done: got %b, expected %b (last addr %0d)", frame_done, exp_fd, run_addr);
                end
                if (frame_done === 1'b1) done_pulses++;
                run_len = 0;
                high_len++;
            end
            checks++;
            if (pix_ready !== ((acc_n - pop_n) < DEPTH)) begin
                errors++;
                $display("FAIL pix_ready: got %b with %0d buffered, expected %b",
                         pix_ready, acc_n - pop_n, ((acc_n - pop_n) < DEPTH));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rd_en     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        commits.delete();
        sent_data.delete();
        done_pulses = 0;
    endtask

    // Sends n pixels back-to-back; pixel i carries sof = sof_mask[i].
    task automatic send(input int n, input logic [31:0] sof_mask, output bit saw_full);
        int            sent;
        bit            acc_now;
        logic [DW-1:0] d;
        sent     = 0;
        saw_full = 1'b0;
        d        = $urandom;
        for (int cyc = 0; cyc < 400 && sent < n; cyc++) begin
            pix_valid = 1'b1;
            pix_sof   = sof_mask[sent];
            pix_data  = d;
            acc_now   = (pix_ready === 1'b1);
            if (!acc_now) saw_full = 1'b1;
            @(negedge clk);
            if (acc_now) begin
                sent_data.push_back(d);
                sent++;
                d = $urandom;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && wr_en === 1'b1 && acc_n == pop_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL reset_wr_en: got %b, expected 1", wr_en); end
        checks++;
        if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d, expected 0", wr_addr); end
        checks++;
        if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h, expected 0", wr_data); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b, expected 1", pix_ready); end
    endtask

    task automatic test_single();
        do_reset();
        pix_data  = 32'hA5A5_A5A5;
        pix_sof   = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL single_early: wr_en got %b on accept edge, expected 1", wr_en); end
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || wr_addr !== AW'(1) || wr_data !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL single_hold%0d: got wr_en=%b addr=%0d data=%h, expected 0/1/a5a5a5a5", i, wr_en, wr_addr, wr_data);
            end
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL single_release: wr_en got %b, expected 1", wr_en); end
    endtask

    task automatic test_frame_wrap();
        bit            full_seen;
        bit            ok;
        logic [AW-1:0] exp_a [9];
        exp_a = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
        do_reset();
        send(9, 32'h1, full_seen);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_drain: %0d writes still outstanding", exp_q.size()); end
        checks++;
        if (!full_seen) begin errors++; $display("FAIL wrap_full: pix_ready never low, expected low with 4 buffered"); end
        checks++;
        if (commits.size() != 9) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes, expected 9", commits.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (commits[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %0d, expected %0d", i, commits[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (done_pulses != 2) begin errors++; $display("FAIL wrap_frame_done: got %0d pulses, expected 2", done_pulses); end
    endtask

    task automatic test_retry();
        bit full_seen;
        bit ok;
        bit found;
        do_reset();
        send(2, 32'h1, full_seen);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_en === 1'b0 && wr_addr === AW'(2)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL retry_start: write to addr 2 never seen, expected one"); end
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL retry_abort: wr_en got %b, expected 1", wr_en); end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL retry_wait: wr_en got %b, expected 1", wr_en); end
        rd_en = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || wr_addr !== AW'(2) || wr_data !== sent_data[1]) begin
                errors++;
                $display("FAIL retry_reissue%0d: got wr_en=%b addr=%0d data=%h, expected 0/2/%h",
                         i, wr_en, wr_addr, wr_data, sent_data[1]);
            end
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL retry_release: wr_en got %b, expected 1", wr_en); end
        drain(ok);
        checks++;
        if (!ok || commits.size() != 2) begin
            errors++;
            $display("FAIL retry_commits: got %0d committed writes, expected 2", commits.size());
        end
    endtask

    task automatic test_sof_mid();
        bit            full_seen;
        bit            ok;
        logic [AW-1:0] exp_a [6];
        exp_a = '{1, 2, 1, 2, 1, 2};
        do_reset();
        send(6, 32'h15, full_seen);
        drain(ok);
        checks++;
        if (!ok || commits.size() != 6) begin
            errors++;
            $display("FAIL sof_count: got %0d writes, expected 6", commits.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (commits[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL sof_addr%0d: got %0d, expected %0d", i, commits[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (done_pulses != 0) begin errors++; $display("FAIL sof_frame_done: got %0d pulses, expected 0", done_pulses); end
    endtask

    task automatic test_reset_mid();
        bit full_seen;
        bit wrote;
        do_reset();
        send(4, 32'h1, full_seen);
        checks++;
        if (wr_en !== 1'b0 || (acc_n - pop_n) != 3) begin
            errors++;
            $display("FAIL rstmid_setup: got wr_en=%b buffered=%0d, expected 0 and 3", wr_en, acc_n - pop_n);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: got wr_en=%b addr=%0d pix_ready=%b, expected 1/0/1", wr_en, wr_addr, pix_ready);
        end
        wrote = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b1) wrote = 1'b1;
        end
        checks++;
        if (wrote) begin errors++; $display("FAIL rstmid_quiet: wr_en went low after reset, expected no writes"); end
    endtask

    task automatic test_rd_block();
        int            accepts;
        bit            acc_now;
        bit            wrote;
        bit            ok;
        do_reset();
        rd_en   = 1'b0;
        accepts = 0;
        wrote   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (accepts == 0);
            pix_data  = $urandom;
            acc_now   = (pix_ready === 1'b1);
            @(negedge clk);
            if (acc_now) accepts++;
            if (wr_en !== 1'b1) wrote = 1'b1;
        end
        checks++;
        if (accepts != DEPTH) begin errors++; $display("FAIL rdblk_accepts: got %0d, expected %0d", accepts, DEPTH); end
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL rdblk_ready: got %b, expected 0", pix_ready); end
        checks++;
        if (wrote) begin errors++; $display("FAIL rdblk_quiet: wr_en low while rd_en low, expected high"); end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rd_en     = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== AW'(1)) begin
            errors++;
            $display("FAIL rdblk_resume: got wr_en=%b addr=%0d, expected 0/1", wr_en, wr_addr);
        end
        drain(ok);
        checks++;
        if (!ok || commits.size() != 4 || done_pulses != 1) begin
            errors++;
            $display("FAIL rdblk_drain: got %0d writes %0d frame_done, expected 4 and 1", commits.size(), done_pulses);
        end
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pix_valid = ($urandom_range(0, 2) != 0);
            pix_sof   = ($urandom_range(0, 7) == 0);
            pix_data  = $urandom;
            rd_en     = ($urandom_range(0, 5) != 0);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rd_en     = 1'b1;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_drain: %0d writes outstanding, expected 0", exp_q.size()); end
        checks++;
        if (commits.size() != acc_n) begin
            errors++;
            $display("FAIL random_count: got %0d writes for %0d pixels", commits.size(), acc_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_wrap();
        test_retry();
        test_sof_mid();
        test_reset_mid();
        test_rd_block();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
